flag_ctx_reg: RTL and testbench
===============================

FLAG_CTX_REG -- requirements
Module: flag_ctx_reg

Interface
REQ-001 Parameter NFLAGS, default 4, number of status flags held (bit 0 Z, 1 C, 2 S, 3 O; higher bits generic).
REQ-002 Parameter DEPTH, default 4, number of save-stack entries, range 1..16.
REQ-003 Port clock  in  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  in  1  asynchronous, active-low reset.
REQ-005 Port flags_in  in  NFLAGS  new flag values from the ALU.
REQ-006 Port flag_we  in  NFLAGS  per-flag write enable; bit i set updates flag i only.
REQ-007 Port push  in  1  save current flags onto the stack (interrupt or call entry).
REQ-008 Port pop  in  1  restore flags from the stack top (return).
REQ-009 Port err_clr  in  1  clear sticky error bits.
REQ-010 Port flags_out  out  NFLAGS  registered current flags.
REQ-011 Port level  out  $clog2(DEPTH+1)  number of valid stack entries.
REQ-012 Port full, empty  out  1 each  level==DEPTH, level==0, combinational from level.
REQ-013 Port ovf_err, unf_err  out  1 each  sticky push-when-full / pop-when-empty flags.

Function
REQ-014 Plain update, no push or pop: flags_out[i] <= flags_in[i] where flag_we[i]=1; other bits hold; one-cycle latency, visible the cycle after the edge.
REQ-015 Push alone, not full: stack[level] <= flags_out value before the edge (pre-update); level +1; REQ-014 update also applies the same edge.
REQ-016 Pop alone, not empty: flags_out <= stack[level-1]; level -1; flag_we ignored that edge, so restore wins over the ALU write.
REQ-017 Push and pop together, not empty: swap; flags_out <= stack top, stack top <= pre-edge flags_out; level unchanged; flag_we ignored.
REQ-018 Push and pop together when empty: pop ignored, unf_err <= 1, push proceeds per REQ-015.
REQ-019 Push when full, pop not asserted: stack and level unchanged, ovf_err <= 1, REQ-014 update still applies.
REQ-020 Pop when empty, push not asserted: level unchanged, unf_err <= 1, REQ-014 update still applies.
REQ-021 Errors are sticky until err_clr; err_clr takes priority over a new error event on the same edge.
REQ-022 level never exceeds DEPTH and never wraps below 0; entries above level hold stale data and are never driven to flags_out.
REQ-023 full and empty are never both 1 (DEPTH>=1).
REQ-024 No combinational path from any input to flags_out, level or the error outputs.

Reset
REQ-025 reset low, asynchronously: flags_out=0, level=0, ovf_err=0, unf_err=0, all stack entries=0; empty=1, full=0.
REQ-026 Reset asserted mid-operation (push/pop pending) aborts that operation; state after release is exactly REQ-025.
REQ-027 First update occurs on the first rising clock edge after reset goes high.

Verification
REQ-028 Reset, then flags_in=4'b1111, flag_we=4'b0101 -> next cycle flags_out=4'b0101; then flag_we=0 with any flags_in -> flags_out holds 4'b0101.
REQ-029 flags_out=4'b1010, push with flags_in=4'b0001 and flag_we=4'b1111 -> stack[0]=4'b1010, flags_out=4'b0001, level=1; then pop with flag_we=4'b1111 -> flags_out=4'b1010, level=0, empty=1.
REQ-030 DEPTH=4: push 5 times with distinct flags -> level=4, full=1, ovf_err=1 after the 5th; pop 4 times -> flags restored in LIFO order; a 5th pop -> unf_err=1, level=0.
REQ-031 level=2, top=4'b0110, flags_out=4'b1001, push and pop together -> flags_out=4'b0110, top=4'b1001, level=2.
REQ-032 unf_err=1, err_clr together with another pop on empty -> unf_err=0 next cycle; reset pulse low mid-push -> all outputs at REQ-025 values.

Source files
------------

// File: rtl/flag_ctx_reg.sv
// Status-flag register with a small LIFO save stack for interrupt/call context.
// Supports per-flag ALU writes, push/pop/swap of the flag context and sticky stack errors.
module flag_ctx_reg #(
    parameter int NFLAGS = 4,
    parameter int DEPTH  = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NFLAGS-1:0]          flags_in,
    input  logic [NFLAGS-1:0]          flag_we,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       err_clr,
    output logic [NFLAGS-1:0]          flags_out,
    output logic [$clog2(DEPTH+1)-1:0] level,
    output logic                       full,
    output logic                       empty,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [NFLAGS-1:0] stack [DEPTH];

    logic              pop_ok;
    logic              swap;
    logic              push_only;
    logic              pop_only;
    logic              ovf_ev;
    logic              unf_ev;
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;
    logic [NFLAGS-1:0] flags_next;
    logic [LW-1:0]     level_next;

    assign full  = (level == DEPTH_L);
    assign empty = (level == '0);

    // A successful pop (alone or as a swap) overrides the ALU write for that edge.
    always_comb begin
        pop_ok     = pop && !empty;
        swap       = push && pop_ok;
        push_only  = push && !pop_ok && !full;
        pop_only   = pop_ok && !push;
        ovf_ev     = push && !pop_ok && full;
        unf_ev     = pop && empty;
        top_idx    = IW'(level - LW'(1));
        wr_idx     = swap ? top_idx : IW'(level);
        flags_next = (flags_out & ~flag_we) | (flags_in & flag_we);
        if (pop_ok) begin
            flags_next = stack[top_idx];
        end
        level_next = level;
        if (push_only) begin
            level_next = level + LW'(1);
        end else if (pop_only) begin
            level_next = level - LW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            flags_out <= '0;
            level     <= '0;
            ovf_err   <= 1'b0;
            unf_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                stack[i] <= '0;
            end
        end else begin
            flags_out <= flags_next;
            level     <= level_next;
            if (push_only || swap) begin
                stack[wr_idx] <= flags_out;
            end
            if (err_clr) begin
                ovf_err <= 1'b0;
                unf_err <= 1'b0;
            end else begin
                ovf_err <= ovf_err | ovf_ev;
                unf_err <= unf_err | unf_ev;
            end
        end
    end

endmodule

// File: tb/tb_flag_ctx_reg.sv
// Self-checking bench for flag_ctx_reg: directed scenarios plus randomized traffic
// compared against a queue-based behavioural model of the flag context stack.
module tb_flag_ctx_reg;

    localparam int NF    = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int SW    = NF + LW + 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [NF-1:0] flags_in = '0;
    logic [NF-1:0] flag_we = '0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          err_clr = 1'b0;
    logic [NF-1:0] flags_out;
    logic [LW-1:0] level;
    logic          full;
    logic          empty;
    logic          ovf_err;
    logic          unf_err;

    int vectors = 0;
    int miscompares = 0;

    logic [NF-1:0] m_flags;
    logic [NF-1:0] m_stack[$];
    logic          m_ovf;
    logic          m_unf;

    flag_ctx_reg #(.NFLAGS(NF), .DEPTH(DEPTH)) dut (
        .clock    (clock),
        .reset    (reset),
        .flags_in (flags_in),
        .flag_we  (flag_we),
        .push     (push),
        .pop      (pop),
        .err_clr  (err_clr),
        .flags_out(flags_out),
        .level    (level),
        .full     (full),
        .empty    (empty),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    always #5 clock = ~clock;

    function automatic logic [SW-1:0] dut_status();
        return {flags_out, level, full, empty, ovf_err, unf_err};
    endfunction

    function automatic logic [SW-1:0] exp_status();
        int n;
        n = m_stack.size();
        return {m_flags, LW'(n), (n == DEPTH), (n == 0), m_ovf, m_unf};
    endfunction

    function automatic void model_reset();
        m_flags = '0;
        m_stack.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endfunction

    // Model: a queue as the stack; a successful pop restores, otherwise the ALU write applies.
    function automatic void model_step(logic p_push, logic p_pop, logic p_clr,
                                       logic [NF-1:0] p_we, logic [NF-1:0] p_in);
        logic [NF-1:0] pre;
        logic ovf_ev;
        logic unf_ev;
        pre = m_flags;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (p_pop && m_stack.size() > 0) begin
            m_flags = m_stack.pop_back();
            if (p_push) m_stack.push_back(pre);
        end else begin
            if (p_pop) unf_ev = 1'b1;
            if (p_push) begin
                if (m_stack.size() < DEPTH) m_stack.push_back(pre);
                else ovf_ev = 1'b1;
            end
            m_flags = (pre & ~p_we) | (p_in & p_we);
        end
        if (p_clr) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            m_ovf = m_ovf | ovf_ev;
            m_unf = m_unf | unf_ev;
        end
    endfunction

    task automatic drive_cycle(input logic p_push, input logic p_pop, input logic p_clr,
                               input logic [NF-1:0] p_we, input logic [NF-1:0] p_in);
        push = p_push;
        pop = p_pop;
        err_clr = p_clr;
        flag_we = p_we;
        flags_in = p_in;
        @(posedge clock);
        #1;
        model_step(p_push, p_pop, p_clr, p_we, p_in);
        push = 1'b0;
        pop = 1'b0;
        err_clr = 1'b0;
        flag_we = '0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #13;
        model_reset();
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #7;
        vectors++;
        if (dut_status() !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_state got %b want %b", dut_status(),
                     {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        do_reset();
    endtask

    task automatic test_plain_update();
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 4'b0101, 4'b1111);
        vectors++;
        if (flags_out !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL plain_write got %b want %b", flags_out, 4'b0101);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'b0000, 4'b1010);
        vectors++;
        if (flags_out !== 4'b0101) begin
            miscompares++;
            $display("[TB] FAIL plain_hold got %b want %b", flags_out, 4'b0101);
        end
        drive_cycle(1'b0, 1'b0, 1'b0, 4'b1010, 4'b1000);
        vectors++;
        if (dut_status() !== exp_status()) begin
            miscompares++;
            $display("[TB] FAIL plain_partial got %b want %b", dut_status(), exp_status());
        end
    endtask

    task automatic test_push_pop();
        do_reset();
        drive_cycle(1'b0, 1'b0, 1'b0, 4'b1111, 4'b1010);
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0001);
        vectors++;
        if ({flags_out, level} !== {4'b0001, 3'd1}) begin
            miscompares++;
            $display("[TB] FAIL push_basic got %b want %b", {flags_out, level}, {4'b0001, 3'd1});
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b1111, 4'b0111);
        vectors++;
        if ({flags_out, level, empty} !== {4'b1010, 3'd0, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL pop_basic got %b want %b", {flags_out, level, empty},
                     {4'b1010, 3'd0, 1'b1});
        end
    endtask

    task automatic test_overflow_underflow();
        logic [NF-1:0] want;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'(i + 1));
        end
        vectors++;
        if ({level, full, ovf_err, flags_out} !== {3'd4, 1'b1, 1'b1, 4'd5}) begin
            miscompares++;
            $display("[TB] FAIL overflow got %b want %b", {level, full, ovf_err, flags_out},
                     {3'd4, 1'b1, 1'b1, 4'd5});
        end
        for (int i = 3; i >= 0; i--) begin
            drive_cycle(1'b0, 1'b1, 1'b0, 4'b1111, 4'b1111);
            want = 4'(i);
            vectors++;
            if (flags_out !== want) begin
                miscompares++;
                $display("[TB] FAIL lifo_order got %b want %b", flags_out, want);
            end
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b1111);
        vectors++;
        if ({level, empty, unf_err, ovf_err, flags_out} !== {3'd0, 1'b1, 1'b1, 1'b1, 4'd0}) begin
            miscompares++;
            $display("[TB] FAIL underflow got %b want %b", {level, empty, unf_err, ovf_err, flags_out},
                     {3'd0, 1'b1, 1'b1, 1'b1, 4'd0});
        end
    endtask

    task automatic test_swap();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0110);
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1001);
        drive_cycle(1'b1, 1'b1, 1'b0, 4'b1111, 4'b1111);
        vectors++;
        if ({flags_out, level} !== {4'b0110, 3'd2}) begin
            miscompares++;
            $display("[TB] FAIL swap got %b want %b", {flags_out, level}, {4'b0110, 3'd2});
        end
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        vectors++;
        if ({flags_out, level} !== {4'b1001, 3'd1}) begin
            miscompares++;
            $display("[TB] FAIL swap_top got %b want %b", {flags_out, level}, {4'b1001, 3'd1});
        end
        do_reset();
        drive_cycle(1'b1, 1'b1, 1'b0, 4'b1111, 4'b0011);
        vectors++;
        if ({flags_out, level, unf_err} !== {4'b0011, 3'd1, 1'b1}) begin
            miscompares++;
            $display("[TB] FAIL pushpop_empty got %b want %b", {flags_out, level, unf_err},
                     {4'b0011, 3'd1, 1'b1});
        end
    endtask

    task automatic test_err_clr();
        do_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        vectors++;
        if (unf_err !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL unf_set got %b want %b", unf_err, 1'b1);
        end
        drive_cycle(1'b0, 1'b1, 1'b1, 4'b0000, 4'b0000);
        vectors++;
        if (unf_err !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL err_clr_priority got %b want %b", unf_err, 1'b0);
        end
    endtask

    task automatic test_reset_mid_push();
        do_reset();
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b1101);
        drive_cycle(1'b1, 1'b0, 1'b0, 4'b1111, 4'b0110);
        push = 1'b1;
        flag_we = 4'b1111;
        flags_in = 4'b1111;
        #2;
        reset = 1'b0;
        #1;
        vectors++;
        if (dut_status() !== {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0}) begin
            miscompares++;
            $display("[TB] FAIL reset_mid_push got %b want %b", dut_status(),
                     {4'b0000, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        push = 1'b0;
        flag_we = '0;
        @(negedge clock);
        reset = 1'b1;
        model_reset();
        drive_cycle(1'b0, 1'b1, 1'b0, 4'b0000, 4'b0000);
        vectors++;
        if (dut_status() !== exp_status()) begin
            miscompares++;
            $display("[TB] FAIL after_release got %b want %b", dut_status(), exp_status());
        end
    endtask

    task automatic test_random();
        logic r_push;
        logic r_pop;
        logic r_clr;
        int   r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r = int'($urandom_range(0, 9));
            r_push = (r < 4);
            r_pop = (r >= 3) && (r < 7);
            r_clr = ($urandom_range(0, 15) == 0);
            drive_cycle(r_push, r_pop, r_clr, 4'($urandom), 4'($urandom));
            vectors++;
            if (dut_status() !== exp_status() || (full && empty)) begin
                miscompares++;
                $display("[TB] FAIL random_%0d got %b want %b", n, dut_status(), exp_status());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_plain_update();
        test_push_pop();
        test_overflow_underflow();
        test_swap();
        test_err_clr();
        test_reset_mid_push();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
